// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ALU opcode encodings, ID/EX control bundle and register-index width
package cpu_pkg;
  localparam int REG_W_DEF = 5;
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_NOR = 4'h5;
  localparam logic [3:0] ALU_SLT = 4'h6;
  localparam logic [3:0] ALU_SLL = 4'h7;
  localparam logic [3:0] ALU_SRL = 4'h8;
  localparam logic [3:0] ALU_SRA = 4'h9;
  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
  } ctrl_t;
  localparam int CTRL_W = $bits(ctrl_t);
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an EX-stage load whose destination feeds an ID-stage source
//   ex_valid, ex_mem_read, ex_rt : EX-stage load state
//   id_rs, id_rt                 : ID-stage source indices
//   hazard                       : stall request; register 0 never hazards
module load_use_detect #(
  parameter int REG_W = cpu_pkg::REG_W_DEF
) (
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             hazard
);
  assign hazard = ex_valid & ex_mem_read & (ex_rt != '0) & ((ex_rt == id_rs) | (ex_rt == id_rt));
endmodule

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register, priority Flush > Stall > capture, async active-low reset
//   inputs : ID operands, instruction fields, ID control, Stall/Flush/InValid
//   outputs: registered EX operands/indices/control, ExValid, combinational LoadUseStall
//   ID_EX_PC_TRACE_EN adds IdPC -> ExPC, handled like the data registers
module id_ex_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              InValid,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  input  logic [DATA_W-1:0] SignExtImm,
  input  logic [REG_W-1:0]  Rs,
  input  logic [REG_W-1:0]  Rt,
  input  logic [REG_W-1:0]  Rd,
  input  logic [REG_W-1:0]  ShamtField,
  input  logic [3:0]        ALUOp,
  input  logic              ALUSrc,
  input  logic              RegDst,
  input  logic              RegWrite,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemToReg,
  input  logic              ShamtSrc,
`ifdef ID_EX_PC_TRACE_EN
  input  logic [DATA_W-1:0] IdPC,
  output logic [DATA_W-1:0] ExPC,
`endif
  output logic [DATA_W-1:0] ExReadData1,
  output logic [DATA_W-1:0] ExReadData2,
  output logic [DATA_W-1:0] ExImm,
  output logic [REG_W-1:0]  ExRs,
  output logic [REG_W-1:0]  ExRt,
  output logic [REG_W-1:0]  ExWriteReg,
  output logic [DATA_W-1:0] ExShamt,
  output logic [3:0]        ExALUOp,
  output logic              ExALUSrc,
  output logic              ExRegWrite,
  output logic              ExMemRead,
  output logic              ExMemWrite,
  output logic              ExMemToReg,
  output logic              ExValid,
  output logic              LoadUseStall
);
  ctrl_t            id_ctrl, ex_ctrl;
  logic [REG_W-1:0] shamt_q;
  // Bubbles carry zero control so an invalid slot can never write or access memory
  assign id_ctrl = InValid ? {ALUOp, ALUSrc, RegWrite, MemRead, MemWrite, MemToReg} : '0;
  assign {ExALUOp, ExALUSrc, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg} = ex_ctrl;
  assign ExShamt = DATA_W'(shamt_q);
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      ExReadData1 <= '0;
      ExReadData2 <= '0;
      ExImm       <= '0;
      ExRs        <= '0;
      ExRt        <= '0;
      ExWriteReg  <= '0;
      shamt_q     <= '0;
      ex_ctrl     <= '0;
      ExValid     <= 1'b0;
`ifdef ID_EX_PC_TRACE_EN
      ExPC        <= '0;
`endif
    end else if (Flush) begin
      ex_ctrl <= '0;
      ExValid <= 1'b0;
    end else if (!Stall) begin
      ExReadData1 <= ReadData1;
      ExReadData2 <= ReadData2;
      ExImm       <= SignExtImm;
      ExRs        <= Rs;
      ExRt        <= Rt;
      ExWriteReg  <= RegDst ? Rd : Rt;
      shamt_q     <= ShamtSrc ? ReadData1[REG_W-1:0] : ShamtField;
      ex_ctrl     <= id_ctrl;
      ExValid     <= InValid;
`ifdef ID_EX_PC_TRACE_EN
      ExPC        <= IdPC;
`endif
    end
  load_use_detect #(.REG_W(REG_W)) u_lud (
    .ex_valid    (ExValid),
    .ex_mem_read (ExMemRead),
    .ex_rt       (ExRt),
    .id_rs       (Rs),
    .id_rt       (Rt),
    .hazard      (LoadUseStall)
  );
endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: directed/scoreboard bench for id_ex_reg
module tb_id_ex_reg;
  import cpu_pkg::*;
  localparam int DW = 32;
  localparam int RW = 5;
  logic Clk = 1'b0, Rst_n = 1'b0, Stall = 1'b0, Flush = 1'b0, InValid = 1'b0;
  logic [DW-1:0] ReadData1 = '0, ReadData2 = '0, SignExtImm = '0;
  logic [RW-1:0] Rs = '0, Rt = '0, Rd = '0, ShamtField = '0;
  logic [3:0] ALUOp = '0;
  logic ALUSrc = 0, RegDst = 0, RegWrite = 0, MemRead = 0, MemWrite = 0, MemToReg = 0, ShamtSrc = 0;
  logic [DW-1:0] ExReadData1, ExReadData2, ExImm, ExShamt;
  logic [RW-1:0] ExRs, ExRt, ExWriteReg;
  logic [3:0] ExALUOp;
  logic ExALUSrc, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg, ExValid, LoadUseStall;
`ifdef ID_EX_PC_TRACE_EN
  logic [DW-1:0] IdPC = '0, ExPC;
`endif
  typedef struct packed {
    logic [DW-1:0] rd1, rd2, imm, shamt;
    logic [RW-1:0] rs, rt, wr;
    logic [3:0] aluop;
    logic alusrc, regwrite, memread, memwrite, memtoreg, valid;
  } out_t;
  out_t m, q[$];
  int total = 0, bad = 0;

  id_ex_reg dut (
    .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Flush(Flush), .InValid(InValid),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .SignExtImm(SignExtImm),
    .Rs(Rs), .Rt(Rt), .Rd(Rd), .ShamtField(ShamtField),
    .ALUOp(ALUOp), .ALUSrc(ALUSrc), .RegDst(RegDst), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg), .ShamtSrc(ShamtSrc),
`ifdef ID_EX_PC_TRACE_EN
    .IdPC(IdPC), .ExPC(ExPC),
`endif
    .ExReadData1(ExReadData1), .ExReadData2(ExReadData2), .ExImm(ExImm),
    .ExRs(ExRs), .ExRt(ExRt), .ExWriteReg(ExWriteReg), .ExShamt(ExShamt),
    .ExALUOp(ExALUOp), .ExALUSrc(ExALUSrc), .ExRegWrite(ExRegWrite),
    .ExMemRead(ExMemRead), .ExMemWrite(ExMemWrite), .ExMemToReg(ExMemToReg),
    .ExValid(ExValid), .LoadUseStall(LoadUseStall)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic out_t sample();
    out_t o;
    o = {ExReadData1, ExReadData2, ExImm, ExShamt, ExRs, ExRt, ExWriteReg, ExALUOp,
         ExALUSrc, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg, ExValid};
    return o;
  endfunction

  function automatic out_t nxt(input out_t c);
    out_t n = c;
    if (Flush) begin
      n.valid = 0; n.aluop = 0; n.alusrc = 0; n.regwrite = 0;
      n.memread = 0; n.memwrite = 0; n.memtoreg = 0;
    end else if (!Stall) begin
      n.rd1 = ReadData1; n.rd2 = ReadData2; n.imm = SignExtImm;
      n.rs = Rs; n.rt = Rt; n.wr = RegDst ? Rd : Rt;
      n.shamt = ShamtSrc ? {27'b0, ReadData1[4:0]} : {27'b0, ShamtField};
      n.valid = InValid;
      n.aluop = InValid ? ALUOp : 4'h0;
      n.alusrc = InValid & ALUSrc; n.regwrite = InValid & RegWrite;
      n.memread = InValid & MemRead; n.memwrite = InValid & MemWrite;
      n.memtoreg = InValid & MemToReg;
    end
    return n;
  endfunction

  function automatic logic exp_lus();
    return m.valid && m.memread && m.rt != 0 && (m.rt == Rs || m.rt == Rt);
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input out_t o, input out_t e);
    chk({tag, ".rd1"}, o.rd1, e.rd1);
    chk({tag, ".rd2"}, o.rd2, e.rd2);
    chk({tag, ".imm"}, o.imm, e.imm);
    chk({tag, ".shamt"}, o.shamt, e.shamt);
    chk({tag, ".rs"}, 32'(o.rs), 32'(e.rs));
    chk({tag, ".rt"}, 32'(o.rt), 32'(e.rt));
    chk({tag, ".wr"}, 32'(o.wr), 32'(e.wr));
    chk({tag, ".ctrl"}, 32'({o.aluop, o.alusrc, o.regwrite, o.memread, o.memwrite, o.memtoreg}),
        32'({e.aluop, e.alusrc, e.regwrite, e.memread, e.memwrite, e.memtoreg}));
    chk({tag, ".valid"}, 32'(o.valid), 32'(e.valid));
  endtask

  task automatic cycle(input string tag);
    m = nxt(m);
    q.push_back(m);
    @(posedge Clk);
    #1;
    chk_all(tag, sample(), q.pop_front());
    chk({tag, ".lus"}, 32'(LoadUseStall), 32'(exp_lus()));
  endtask

  task automatic rnd();
    ReadData1 = $urandom; ReadData2 = $urandom; SignExtImm = $urandom;
    Rs = RW'($urandom); Rt = RW'($urandom); Rd = RW'($urandom); ShamtField = RW'($urandom);
    ALUOp = 4'($urandom); ALUSrc = 1'($urandom); RegDst = 1'($urandom);
    RegWrite = 1'($urandom); MemRead = 1'($urandom); MemWrite = 1'($urandom);
    MemToReg = 1'($urandom); ShamtSrc = 1'($urandom);
  endtask

  initial begin
    m = '0;
    #2;
    chk_all("reset", sample(), '0);
    chk("reset.lus", 32'(LoadUseStall), 32'd0);
    @(negedge Clk) Rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rnd(); InValid = 1; Stall = 0; Flush = 0;
      cycle("cap");
    end
    for (int i = 0; i < 12; i++) begin
      rnd(); InValid = 1'($urandom); Stall = 1'($urandom); Flush = ($urandom_range(0, 3) == 0);
      cycle("mix");
    end
    rnd(); Stall = 0; Flush = 0; InValid = 1; ReadData1 = 32'h0000_0024; ShamtSrc = 1;
    cycle("shamt");
    chk("shamt.val", ExShamt, 32'h0000_0004);
    chk("shamt.valid", 32'(ExValid), 32'd1);
    rnd(); Stall = 1; Flush = 1; RegWrite = 1; InValid = 1;
    cycle("stall_flush");
    chk("sf.valid", 32'(ExValid), 32'd0);
    chk("sf.regwrite", 32'(ExRegWrite), 32'd0);
    rnd(); Stall = 0; Flush = 0; InValid = 1; SignExtImm = 32'hFFFF_8000;
    cycle("imm_cap");
    for (int i = 0; i < 3; i++) begin
      SignExtImm = $urandom; Stall = 1;
      cycle("imm_hold");
      chk("imm.held", ExImm, 32'hFFFF_8000);
    end
    Stall = 0; SignExtImm = 32'h0000_1234;
    cycle("imm_rel");
    chk("imm.new", ExImm, 32'h0000_1234);
    rnd(); InValid = 1; MemRead = 1; Rt = 5'd8; Stall = 0; Flush = 0;
    cycle("lw8");
    Rs = 5'd8; Rt = 5'd3; #1;
    chk("lus.rs_hit", 32'(LoadUseStall), 32'd1);
    Stall = 1; Flush = 1; #1;
    chk("lus.indep", 32'(LoadUseStall), 32'd1);
    Stall = 0; Flush = 0; Rs = 5'd9; #1;
    chk("lus.miss", 32'(LoadUseStall), 32'd0);
    Rt = 5'd8; #1;
    chk("lus.rt_hit", 32'(LoadUseStall), 32'd1);
    rnd(); InValid = 1; MemRead = 1; Rt = 5'd0; Rs = 5'd0;
    cycle("lw0");
    chk("lus.r0", 32'(LoadUseStall), 32'd0);
    rnd(); InValid = 0; MemWrite = 1; RegDst = 1; Rd = 5'd31;
    cycle("bubble");
    chk("bub.memwrite", 32'(ExMemWrite), 32'd0);
    chk("bub.valid", 32'(ExValid), 32'd0);
    chk("bub.wr", 32'(ExWriteReg), 32'd31);
    ReadData1 = 32'hA5A5_0003; ReadData2 = 32'h1; SignExtImm = 32'h2;
    Rs = 5'd7; Rt = 5'd9; Rd = 5'd10; ShamtField = 5'd5; ShamtSrc = 0; RegDst = 1;
    ALUOp = ALU_SRA; ALUSrc = 1; RegWrite = 1; MemRead = 1; MemWrite = 1; MemToReg = 1; InValid = 1;
    cycle("full");
    Stall = 1; #2;
    Rst_n = 1'b0; #1;
    chk_all("async_rst", sample(), '0);
    chk("async_rst.lus", 32'(LoadUseStall), 32'd0);
    m = '0;
    @(negedge Clk) Rst_n = 1'b1;
    rnd(); InValid = 1; Stall = 0; Flush = 0;
    cycle("post_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
